// File: rtl/lagarto_plic_pkg.sv
// rtl/lagarto_plic_pkg.sv - shared PLIC arbitration types and constants
// Contents:
//   interrupt_priority_t / interrupt_id_t : default-width priority and ID types
//   NO_INTERRUPT_PRIORITY / NO_INTERRUPT_ID : the "nothing pending" encoding
//   max_candidate_t : {prio, id} pair carried through the max reduction
package lagarto_plic_pkg;

    localparam int DEFAULT_NUM_SOURCES    = 31;
    localparam int DEFAULT_PRIORITY_WIDTH = 3;
    localparam int DEFAULT_ID_WIDTH       = $clog2(DEFAULT_NUM_SOURCES + 1);

    typedef logic [DEFAULT_PRIORITY_WIDTH-1:0] interrupt_priority_t;
    typedef logic [DEFAULT_ID_WIDTH-1:0]       interrupt_id_t;

    localparam interrupt_priority_t NO_INTERRUPT_PRIORITY = '0;
    localparam interrupt_id_t       NO_INTERRUPT_ID       = '0;

    // "priority" is a reserved word, so the field is named prio.
    typedef struct packed {
        interrupt_priority_t prio;
        interrupt_id_t       id;
    } max_candidate_t;

endpackage

// File: rtl/lagarto_plic_lane_max.sv
// rtl/lagarto_plic_lane_max.sv - combinational LANES+1 input priority/ID max reduction
// Ports:
//   run_prio, run_id   : running maximum carried from earlier chunks
//   lane_prio, lane_id : packed candidates of the current chunk, (0,0) if not qualifying
//   max_prio, max_id   : winner; higher priority wins, equal priority -> greater ID
module lagarto_plic_lane_max
    import lagarto_plic_pkg::*;
#(
    parameter int LANES          = 4,
    parameter int PRIORITY_WIDTH = DEFAULT_PRIORITY_WIDTH,
    parameter int ID_WIDTH       = DEFAULT_ID_WIDTH
) (
    input  logic [PRIORITY_WIDTH-1:0]       run_prio,
    input  logic [ID_WIDTH-1:0]             run_id,
    input  logic [LANES*PRIORITY_WIDTH-1:0] lane_prio,
    input  logic [LANES*ID_WIDTH-1:0]       lane_id,
    output logic [PRIORITY_WIDTH-1:0]       max_prio,
    output logic [ID_WIDTH-1:0]             max_id
);

    // The (prio, id) ordering is a lexicographic max, so folding the
    // candidates in any order gives the same winner.
    always_comb begin
        max_prio = run_prio;
        max_id   = run_id;
        for (int j = 0; j < LANES; j++) begin
            if ((lane_prio[j*PRIORITY_WIDTH +: PRIORITY_WIDTH] > max_prio) ||
                ((lane_prio[j*PRIORITY_WIDTH +: PRIORITY_WIDTH] == max_prio) &&
                 (lane_id[j*ID_WIDTH +: ID_WIDTH] > max_id))) begin
                max_prio = lane_prio[j*PRIORITY_WIDTH +: PRIORITY_WIDTH];
                max_id   = lane_id[j*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

endmodule

// File: rtl/lagarto_plic_sweep_arbiter.sv
// rtl/lagarto_plic_sweep_arbiter.sv - time-multiplexed PLIC target max-priority arbiter
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   pending_i      : gateway pending bits, bit i-1 is ID i
//   enable_i       : target enable bits, bit i-1 is ID i
//   priority_i     : packed priorities, slice i-1 is ID i
//   threshold_i    : target threshold, sampled on the publish cycle
//   claim_i        : claim read pulse; clears outputs and restarts the sweep
//   max_id_o       : published winning ID (0 = none)
//   max_priority_o : published winning priority
//   eip_o          : published priority > threshold
//   sweep_done_o   : one-cycle pulse with each new publish
module lagarto_plic_sweep_arbiter
    import lagarto_plic_pkg::*;
#(
    parameter  int NUM_SOURCES    = 31,
    parameter  int PRIORITY_WIDTH = 3,
    parameter  int LANES          = 4,
    localparam int ID_WIDTH       = $clog2(NUM_SOURCES + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_SOURCES-1:0]              pending_i,
    input  logic [NUM_SOURCES-1:0]              enable_i,
    input  logic [NUM_SOURCES*PRIORITY_WIDTH-1:0] priority_i,
    input  logic [PRIORITY_WIDTH-1:0]           threshold_i,
    input  logic                                claim_i,
    output logic [ID_WIDTH-1:0]                 max_id_o,
    output logic [PRIORITY_WIDTH-1:0]           max_priority_o,
    output logic                                eip_o,
    output logic                                sweep_done_o
);

    localparam int SWEEPS    = (NUM_SOURCES + LANES - 1) / LANES;
    localparam int CNT_WIDTH = (SWEEPS > 1) ? $clog2(SWEEPS) : 1;
    // Chunk table is padded to a power of two so the counter indexes it exactly;
    // padding chunks are never selected because the counter wraps at SWEEPS-1.
    localparam int DEPTH     = 1 << CNT_WIDTH;

    localparam logic [CNT_WIDTH-1:0]      LAST_CHUNK = CNT_WIDTH'(SWEEPS - 1);
    localparam logic [PRIORITY_WIDTH-1:0] ZERO_PRIO  = PRIORITY_WIDTH'(NO_INTERRUPT_PRIORITY);
    localparam logic [ID_WIDTH-1:0]       ZERO_ID    = ID_WIDTH'(NO_INTERRUPT_ID);

    logic [CNT_WIDTH-1:0]            chunk_q;
    logic [PRIORITY_WIDTH-1:0]       run_prio_q;
    logic [ID_WIDTH-1:0]             run_id_q;

    logic [LANES*PRIORITY_WIDTH-1:0] chunk_prio [DEPTH];
    logic [LANES*ID_WIDTH-1:0]       chunk_id   [DEPTH];
    logic [PRIORITY_WIDTH-1:0]       red_prio;
    logic [ID_WIDTH-1:0]             red_id;

    // Candidate for every (chunk, lane) slot. Non-qualifying sources and
    // phantom IDs beyond NUM_SOURCES present as (0, 0) so they can never win.
    for (genvar c = 0; c < DEPTH; c++) begin : g_chunk
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            localparam int SRC = c * LANES + j + 1;
            if ((c < SWEEPS) && (SRC <= NUM_SOURCES)) begin : g_real
                logic qual;
                assign qual = pending_i[SRC-1] & enable_i[SRC-1] &
                              (|priority_i[(SRC-1)*PRIORITY_WIDTH +: PRIORITY_WIDTH]);
                assign chunk_prio[c][j*PRIORITY_WIDTH +: PRIORITY_WIDTH] =
                    qual ? priority_i[(SRC-1)*PRIORITY_WIDTH +: PRIORITY_WIDTH] : ZERO_PRIO;
                assign chunk_id[c][j*ID_WIDTH +: ID_WIDTH] =
                    qual ? ID_WIDTH'(SRC) : ZERO_ID;
            end else begin : g_phantom
                assign chunk_prio[c][j*PRIORITY_WIDTH +: PRIORITY_WIDTH] = ZERO_PRIO;
                assign chunk_id[c][j*ID_WIDTH +: ID_WIDTH]               = ZERO_ID;
            end
        end
    end

    lagarto_plic_lane_max #(
        .LANES          (LANES),
        .PRIORITY_WIDTH (PRIORITY_WIDTH),
        .ID_WIDTH       (ID_WIDTH)
    ) u_lane_max (
        .run_prio  (run_prio_q),
        .run_id    (run_id_q),
        .lane_prio (chunk_prio[chunk_q]),
        .lane_id   (chunk_id[chunk_q]),
        .max_prio  (red_prio),
        .max_id    (red_id)
    );

    // The running max is cleared on the publish edge, so chunk 0 always
    // starts from (0, 0) without needing a separate select on the reducer input.
    always_ff @(posedge clk_i) begin
        if (rst_i || claim_i) begin
            chunk_q        <= '0;
            run_prio_q     <= ZERO_PRIO;
            run_id_q       <= ZERO_ID;
            max_id_o       <= ZERO_ID;
            max_priority_o <= ZERO_PRIO;
            eip_o          <= 1'b0;
            sweep_done_o   <= 1'b0;
        end else if (chunk_q == LAST_CHUNK) begin
            chunk_q        <= '0;
            run_prio_q     <= ZERO_PRIO;
            run_id_q       <= ZERO_ID;
            max_id_o       <= red_id;
            max_priority_o <= red_prio;
            eip_o          <= (red_prio > threshold_i);
            sweep_done_o   <= 1'b1;
        end else begin
            chunk_q        <= chunk_q + 1'b1;
            run_prio_q     <= red_prio;
            run_id_q       <= red_id;
            sweep_done_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lagarto_plic_sweep_arbiter.sv
// tb/tb_lagarto_plic_sweep_arbiter.sv - scoreboard bench for lagarto_plic_sweep_arbiter
module tb_lagarto_plic_sweep_arbiter;

    localparam int N  = 31;
    localparam int PW = 3;
    localparam int L  = 4;
    localparam int IW = 5;
    localparam int S  = (N + L - 1) / L;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            claim = 1'b0;
    logic [N-1:0]    pend_bus = '0;
    logic [N-1:0]    en_bus = '0;
    logic [N*PW-1:0] prio_bus = '0;
    logic [PW-1:0]   thr = '0;
    logic [IW-1:0]   max_id;
    logic [PW-1:0]   max_prio;
    logic            eip;
    logic            sweep_done;

    lagarto_plic_sweep_arbiter #(
        .NUM_SOURCES    (N),
        .PRIORITY_WIDTH (PW),
        .LANES          (L)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pending_i      (pend_bus),
        .enable_i       (en_bus),
        .priority_i     (prio_bus),
        .threshold_i    (thr),
        .claim_i        (claim),
        .max_id_o       (max_id),
        .max_priority_o (max_prio),
        .eip_o          (eip),
        .sweep_done_o   (sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit pub;
        int id;
        int pr;
        bit eip;
    } exp_t;

    exp_t q[$];

    // Source state seen by the model, indexed by interrupt ID.
    bit pd [1:N];
    bit eb [1:N];
    int pa [1:N];

    int cur_cyc = -1;
    int vectors = 0;
    int miscompares = 0;
    int sweep_pos = 0;
    int best_id = 0;
    int best_pr = 0;

    task automatic apply();
        for (int i = 1; i <= N; i++) begin
            pend_bus[i-1] = pd[i];
            en_bus[i-1]   = eb[i];
            prio_bus[(i-1)*PW +: PW] = PW'(pa[i]);
        end
    endtask

    task automatic clear_src();
        for (int i = 1; i <= N; i++) begin
            pd[i] = 1'b0;
            eb[i] = 1'b0;
            pa[i] = 0;
        end
    endtask

    task automatic set_src(input int id, input bit p, input bit e, input int pr);
        pd[id] = p;
        eb[id] = e;
        pa[id] = pr;
    endtask

    // Reference: IDs are visited in sweep windows of L per cycle; the best
    // qualifying (priority, ID) seen over a full window of S cycles is published
    // the cycle after the window closes. A claim discards everything.
    task automatic run_cycle(input bit clm);
        claim = clm;
        apply();
        if (clm) begin
            sweep_pos = 0;
            best_id = 0;
            best_pr = 0;
            q.push_back('{cur_cyc + 1, 1'b0, 0, 0, 1'b0});
        end else begin
            for (int j = 0; j < L; j++) begin
                int id;
                id = sweep_pos * L + j + 1;
                if (id <= N && pd[id] && eb[id] && pa[id] > 0) begin
                    if (pa[id] > best_pr || (pa[id] == best_pr && id > best_id)) begin
                        best_pr = pa[id];
                        best_id = id;
                    end
                end
            end
            if (sweep_pos == S - 1) begin
                q.push_back('{cur_cyc + 1, 1'b1, best_id, best_pr, best_pr > int'(thr)});
                sweep_pos = 0;
                best_id = 0;
                best_pr = 0;
            end else begin
                sweep_pos++;
            end
        end
        @(posedge clk);
        #1;
        cur_cyc++;
        claim = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        claim = 1'b0;
        @(posedge clk);
        #1;
        cur_cyc = -1;
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        cur_cyc = 0;
        sweep_pos = 0;
        best_id = 0;
        best_pr = 0;
        q.push_back('{0, 1'b0, 0, 0, 1'b0});
    endtask

    always @(negedge clk) begin
        if (cur_cyc >= 0) begin
            while (q.size() > 0 && q[0].cyc < cur_cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missed_check: expected at cycle %0d not observed (now cycle %0d)", q[0].cyc, cur_cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cur_cyc) begin
                exp_t e;
                e = q.pop_front();
                vectors++;
                if (sweep_done !== e.pub || max_id !== IW'(e.id) || max_prio !== PW'(e.pr) || eip !== e.eip) begin
                    miscompares++;
                    $display("FAIL %s cycle %0d: got done=%0b id=%0d prio=%0d eip=%0b, expected done=%0b id=%0d prio=%0d eip=%0b",
                             e.pub ? "publish" : "clear", cur_cyc, sweep_done, max_id, max_prio, eip,
                             e.pub, e.id, e.pr, e.eip);
                end
            end else if (sweep_done !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse cycle %0d: got sweep_done=%0b, expected 0", cur_cyc, sweep_done);
            end
        end
    end

    initial begin
        clear_src();
        apply();
        repeat (2) @(posedge clk);
        #1;
        do_reset(3);

        // single source ID 5, priority 3, threshold 0: publishes in cycles 8 and 16
        set_src(5, 1, 1, 3);
        thr = 3'd0;
        repeat (2 * S + 1) run_cycle(1'b0);

        // equal priorities: greater ID wins
        do_reset(2);
        clear_src();
        set_src(2, 1, 1, 7);
        set_src(30, 1, 1, 7);
        repeat (2 * S) run_cycle(1'b0);

        // threshold is strict, then lowered
        do_reset(2);
        clear_src();
        set_src(9, 1, 1, 2);
        thr = 3'd2;
        repeat (S) run_cycle(1'b0);
        thr = 3'd1;
        repeat (S) run_cycle(1'b0);

        // disabled high-priority source and a priority-0 source never qualify
        do_reset(2);
        clear_src();
        thr = 3'd0;
        set_src(31, 1, 0, 7);
        set_src(1, 1, 1, 0);
        repeat (2 * S) run_cycle(1'b0);

        // claim on the publish cycle suppresses the result; republish S cycles later
        do_reset(2);
        clear_src();
        set_src(12, 1, 1, 4);
        repeat (S - 1) run_cycle(1'b0);
        run_cycle(1'b1);
        repeat (S + 1) run_cycle(1'b0);

        // reset in the middle of a sweep abandons the partial result
        clear_src();
        set_src(3, 1, 1, 6);
        repeat (3) run_cycle(1'b0);
        do_reset(2);
        clear_src();
        set_src(20, 1, 1, 5);
        repeat (2 * S + 1) run_cycle(1'b0);

        // randomized live inputs, thresholds and claims
        clear_src();
        for (int i = 1; i <= N; i++) begin
            set_src(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end
        for (int c = 0; c < 3000; c++) begin
            int n_chg;
            n_chg = int'($urandom_range(0, 3));
            for (int m = 0; m < n_chg; m++) begin
                int id;
                id = int'($urandom_range(1, N));
                set_src(id, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
            end
            if ($urandom_range(0, 15) == 0) thr = PW'($urandom_range(0, 7));
            run_cycle($urandom_range(0, 24) == 0);
        end

        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover_check: expected at cycle %0d never checked", q[0].cyc);
            void'(q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
